i2c_target: RTL and testbench

- I2C target (responder) answering the bus master on Sda/Scl.
- Oversamples Scl/Sda on the system clock; detects START, repeated START and STOP; matches a 7-bit address.
- Writes: first data byte is a register pointer, following bytes go to a host register bank via a write strobe. Reads: returns bank bytes from the pointer.
- Pointer auto-increments per byte. No clock stretching.

---
 rtl/i2c_target_if.sv | 26 ++
 rtl/i2c_target.sv | 223 ++++++++++++++++++++++
 tb/tb_i2c_target.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_if.sv
// Host-side register bank interface of the I2C target.
//   Rd_data : bank byte at Reg_ptr (bank -> target)
//   Reg_ptr : current register pointer (target -> bank)
//   Wr_en   : one-Clk write strobe (target -> bank)
//   Wr_data : byte to write at Reg_ptr, valid with Wr_en (target -> bank)
//   Busy    : target addressed and transaction in progress (target -> bank)
//   Ack     : one-Clk pulse per ACK driven by the target (target -> bank)
// modport master: the I2C target side; modport slave: the register bank side.
interface i2c_target_if;
  logic [7:0] Rd_data;
  logic [7:0] Reg_ptr;
  logic       Wr_en;
  logic [7:0] Wr_data;
  logic       Busy;
  logic       Ack;

  modport master (
    input  Rd_data,
    output Reg_ptr, Wr_en, Wr_data, Busy, Ack
  );

  modport slave (
    output Rd_data,
    input  Reg_ptr, Wr_en, Wr_data, Busy, Ack
  );
endinterface

// File: rtl/i2c_target.sv
// I2C target (responder). Oversamples Scl/Sda on Clk, detects START,
// repeated START and STOP, matches a 7-bit address and bridges bus
// transfers to a host register bank. First written byte sets the register
// pointer, further written bytes are strobed out on Wr_en; reads return
// bank bytes starting at the pointer. Pointer auto-increments per byte.
// No clock stretching.
// Ports:
//   Clk   : system clock, >= 8x Scl frequency
//   Reset : synchronous, active-high
//   Scl   : bus clock (input only)
//   Sda   : bus data, open-drain (driven low or released)
//   host  : register bank interface (Rd_data, Reg_ptr, Wr_en, Wr_data,
//           Busy, Ack)
module i2c_target #(
  parameter logic [6:0]  TARGET_ADDR = 7'h70,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Scl,
  inout  wire         Sda,
  i2c_target_if.master host
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] ADDR      = 4'd1;
  localparam logic [3:0] ADDR_ACK  = 4'd2;
  localparam logic [3:0] WR_PTR    = 4'd3;
  localparam logic [3:0] WR_ACK    = 4'd4;
  localparam logic [3:0] WR_DATA   = 4'd5;
  localparam logic [3:0] RD_DATA   = 4'd6;
  localparam logic [3:0] RD_ACK    = 4'd7;
  localparam logic [3:0] WAIT_STOP = 4'd8;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_d, sda_d;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, sda_rise, sda_fall;
  logic                   start_det, stop_det;

  logic [3:0] state;
  logic [3:0] bitcnt;
  logic [7:0] shreg;
  logic [7:0] rx_byte;
  logic       rw;
  logic       pend;
  logic       sda_drive_low;

  assign Sda = sda_drive_low ? 1'b0 : 1'bz;

  // Synchronizers and history flops reset to the idle-bus level so that
  // leaving reset never fabricates an edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], Scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], Sda};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign sda_rise  = sda_s & ~sda_d;
  assign sda_fall  = ~sda_s & sda_d;
  assign start_det = sda_fall & scl_s;
  assign stop_det  = sda_rise & scl_s;
  assign rx_byte   = {shreg[6:0], sda_s};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= IDLE;
      bitcnt        <= '0;
      shreg         <= '0;
      rw            <= 1'b0;
      pend          <= 1'b0;
      sda_drive_low <= 1'b0;
      host.Reg_ptr  <= '0;
      host.Wr_en    <= 1'b0;
      host.Wr_data  <= '0;
      host.Busy     <= 1'b0;
      host.Ack      <= 1'b0;
    end else begin
      host.Wr_en <= 1'b0;
      host.Ack   <= 1'b0;
      // Pointer advances the Clk after the write strobe so the strobe
      // itself is seen with the old pointer.
      if (host.Wr_en)
        host.Reg_ptr <= host.Reg_ptr + 8'd1;

      if (stop_det) begin
        state         <= IDLE;
        sda_drive_low <= 1'b0;
        host.Busy     <= 1'b0;
        bitcnt        <= '0;
        pend          <= 1'b0;
      end else if (start_det) begin
        state         <= ADDR;
        sda_drive_low <= 1'b0;
        bitcnt        <= '0;
        pend          <= 1'b0;
      end else begin
        case (state)
          IDLE: ;

          // Receive states share the shift/ACK sequence; pend marks a
          // complete byte waiting for scl_fall to start the ACK.
          ADDR, WR_PTR, WR_DATA: begin
            if (pend) begin
              if (scl_fall) begin
                sda_drive_low <= 1'b1;
                host.Ack      <= 1'b1;
                pend          <= 1'b0;
                if (state == ADDR) begin
                  host.Busy <= 1'b1;
                  state     <= ADDR_ACK;
                end else begin
                  state     <= WR_ACK;
                end
              end
            end else if (scl_rise) begin
              shreg <= rx_byte;
              if (bitcnt == 4'd7) begin
                bitcnt <= '0;
                pend   <= 1'b1;
                case (state)
                  ADDR: begin
                    if (rx_byte[7:1] == TARGET_ADDR) begin
                      rw <= rx_byte[0];
                    end else begin
                      pend      <= 1'b0;
                      host.Busy <= 1'b0;
                      state     <= IDLE;
                    end
                  end
                  WR_PTR:  host.Reg_ptr <= rx_byte;
                  WR_DATA: begin
                    host.Wr_data <= rx_byte;
                    host.Wr_en   <= 1'b1;
                  end
                  default: ;
                endcase
              end else begin
                bitcnt <= bitcnt + 4'd1;
              end
            end
          end

          ADDR_ACK: begin
            if (scl_fall) begin
              bitcnt <= '0;
              if (rw) begin
                sda_drive_low <= ~host.Rd_data[7];
                shreg         <= {host.Rd_data[6:0], 1'b0};
                state         <= RD_DATA;
              end else begin
                sda_drive_low <= 1'b0;
                state         <= WR_PTR;
              end
            end
          end

          WR_ACK: begin
            if (scl_fall) begin
              sda_drive_low <= 1'b0;
              bitcnt        <= '0;
              state         <= WR_DATA;
            end
          end

          // bitcnt counts master rises; each fall presents the next bit,
          // and the fall after the 8th rise hands the bus back.
          RD_DATA: begin
            if (scl_rise) begin
              bitcnt <= bitcnt + 4'd1;
            end else if (scl_fall) begin
              if (bitcnt == 4'd8) begin
                sda_drive_low <= 1'b0;
                bitcnt        <= '0;
                state         <= RD_ACK;
              end else begin
                sda_drive_low <= ~shreg[7];
                shreg         <= {shreg[6:0], 1'b0};
              end
            end
          end

          // The pointer advances for every byte read, whether the master
          // ACKs or NACKs it; only an ACK continues the burst.
          RD_ACK: begin
            if (pend) begin
              if (scl_fall) begin
                pend          <= 1'b0;
                bitcnt        <= '0;
                sda_drive_low <= ~host.Rd_data[7];
                shreg         <= {host.Rd_data[6:0], 1'b0};
                state         <= RD_DATA;
              end
            end else if (scl_rise) begin
              host.Reg_ptr <= host.Reg_ptr + 8'd1;
              if (sda_s)
                state <= WAIT_STOP;
              else
                pend <= 1'b1;
            end
          end

          WAIT_STOP: ;

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Testbench for i2c_target: drives I2C transactions as a bus master and
// checks the target against a transaction-level model of the register
// pointer, write events, ACKs and read bytes.
module tb_i2c_target;
  localparam int Q = 80;  // quarter Scl period in ns (Scl = Clk/32)

  logic clk = 1'b0;
  logic rst;
  logic scl;
  logic sda_m;      // master pulls Sda low when 1
  logic may_drive;  // target is allowed to pull Sda low in this bit
  wire  sda;

  assign sda = sda_m ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_target_if bus ();
  assign bus.Rd_data = 8'h10 + bus.Reg_ptr;

  i2c_target #(.TARGET_ADDR(7'h70), .SYNC_STAGES(2)) dut (
    .Clk   (clk),
    .Reset (rst),
    .Scl   (scl),
    .Sda   (sda),
    .host  (bus.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_cnt  = 0;

  logic [7:0]  m_ptr = 8'h00;
  logic [15:0] wr_q[$];
  logic [15:0] wr_log[$];
  logic [7:0]  rd_log[$];
  logic [7:0]  txb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: write strobes against the model queue, ACK pulses,
  // and the target keeping Sda released wherever it must not drive.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.Wr_en) begin
        wr_log.push_back({bus.Reg_ptr, bus.Wr_data});
        if (wr_q.size() == 0) begin
          check("unexpected_wr_en", 32'd1, 32'd0);
        end else begin
          logic [15:0] e;
          e = wr_q.pop_front();
          check("wr_ptr", {24'd0, bus.Reg_ptr}, {24'd0, e[15:8]});
          check("wr_data", {24'd0, bus.Wr_data}, {24'd0, e[7:0]});
        end
      end
      if (bus.Ack) ack_cnt++;
      if (scl && !may_drive && !sda_m)
        check("sda_released", {31'd0, sda}, 32'd1);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bus master primitives ----------------
  task automatic bus_start();
    sda_m = 1'b0; #Q;
    scl   = 1'b1; #Q;
    sda_m = 1'b1; #Q;
    scl   = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_m = 1'b1; #Q;
    scl   = 1'b1; #Q;
    sda_m = 1'b0; #Q;
  endtask

  task automatic send_bit(input logic b, output logic s);
    sda_m = ~b; #Q;
    scl   = 1'b1; #Q;
    s     = sda; #Q;
    scl   = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack);
    logic s;
    may_drive = 1'b0;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    may_drive = exp_ack;
    send_bit(1'b1, s);
    may_drive = 1'b0;
    check("byte_ack", {31'd0, ~s}, {31'd0, exp_ack});
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic mack);
    logic s;
    logic [7:0] got;
    may_drive = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      got[i] = s;
    end
    may_drive = 1'b0;
    send_bit(~mack, s);
    rd_log.push_back(got);
    check("rd_byte", {24'd0, got}, {24'd0, exp});
  endtask

  task automatic end_checks(input int acks0, input int exp_acks);
    #(6 * 10);
    check("busy_after_stop", {31'd0, bus.Busy}, 32'd0);
    check("ack_count", ack_cnt - acks0, exp_acks);
    check("wr_pending", wr_q.size(), 32'd0);
    check("reg_ptr", {24'd0, bus.Reg_ptr}, {24'd0, m_ptr});
  endtask

  // ---------------- transaction-level model + driver ----------------
  // Write: addr byte, then txb[0] = pointer, txb[1..] = data.
  task automatic txn_write(input logic [6:0] addr);
    logic match;
    int   acks0, exp_acks;
    match    = (addr == 7'h70);
    acks0    = ack_cnt;
    exp_acks = 0;
    bus_start();
    write_byte({addr, 1'b0}, match);
    check("busy_after_addr", {31'd0, bus.Busy}, {31'd0, match});
    if (match) exp_acks++;
    for (int i = 0; i < txb.size(); i++) begin
      if (match) begin
        if (i == 0) m_ptr = txb[0];
        else begin
          wr_q.push_back({m_ptr, txb[i]});
          m_ptr = m_ptr + 8'd1;
        end
        exp_acks++;
      end
      write_byte(txb[i], match);
    end
    bus_stop();
    end_checks(acks0, exp_acks);
  endtask

  // Read n bytes, optionally setting the pointer first with a repeated START.
  task automatic txn_read(input logic set_ptr, input logic [7:0] p, input int n);
    int acks0, exp_acks;
    acks0    = ack_cnt;
    exp_acks = 1;
    bus_start();
    if (set_ptr) begin
      write_byte(8'hE0, 1'b1);
      m_ptr = p;
      write_byte(p, 1'b1);
      exp_acks += 2;
      bus_start();
    end
    write_byte(8'hE1, 1'b1);
    for (int k = 0; k < n; k++) begin
      logic [7:0] e;
      e = 8'h10 + m_ptr;
      m_ptr = m_ptr + 8'd1;
      read_byte(e, k < n - 1);
    end
    bus_stop();
    end_checks(acks0, exp_acks);
  endtask

  initial begin
    logic s;
    rst       = 1'b1;
    scl       = 1'b1;
    sda_m     = 1'b0;
    may_drive = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_reg_ptr", {24'd0, bus.Reg_ptr}, 32'd0);
    check("rst_wr_en", {31'd0, bus.Wr_en}, 32'd0);
    check("rst_wr_data", {24'd0, bus.Wr_data}, 32'd0);
    check("rst_busy", {31'd0, bus.Busy}, 32'd0);
    check("rst_ack", {31'd0, bus.Ack}, 32'd0);
    check("rst_sda", {31'd0, sda}, 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #(4 * 10);

    // Directed write
    txb = '{8'h05, 8'hA5, 8'h3C};
    wr_log.delete();
    txn_write(7'h70);
    check("plan_wr_ptr_lit", {24'd0, bus.Reg_ptr}, 32'h07);
    check("plan_wr_log0_lit", {16'd0, wr_log[0]}, 32'h05A5);
    check("plan_wr_log1_lit", {16'd0, wr_log[1]}, 32'h063C);

    // Directed read with restart
    rd_log.delete();
    wr_log.delete();
    txn_read(1'b1, 8'h10, 2);
    check("plan_rd0_lit", {24'd0, rd_log[0]}, 32'h20);
    check("plan_rd1_lit", {24'd0, rd_log[1]}, 32'h21);
    check("plan_rd_ptr_lit", {24'd0, bus.Reg_ptr}, 32'h12);
    check("plan_rd_no_wr", wr_log.size(), 32'd0);

    // Address mismatch
    txb = '{8'h00};
    txn_write(7'h50);
    check("mismatch_ptr_lit", {24'd0, bus.Reg_ptr}, 32'h12);

    // Pointer wrap
    txb = '{8'hFF, 8'h11, 8'h22};
    wr_log.delete();
    txn_write(7'h70);
    check("wrap_log0_lit", {16'd0, wr_log[0]}, 32'hFF11);
    check("wrap_log1_lit", {16'd0, wr_log[1]}, 32'h0022);
    check("wrap_ptr_lit", {24'd0, bus.Reg_ptr}, 32'h01);

    // Abort after 4 data bits, then a normal write
    begin
      int acks0;
      acks0 = ack_cnt;
      wr_log.delete();
      bus_start();
      write_byte(8'hE0, 1'b1);
      m_ptr = 8'h30;
      write_byte(8'h30, 1'b1);
      for (int i = 0; i < 4; i++) send_bit(i[0], s);
      bus_stop();
      end_checks(acks0, 2);
      check("abort_no_wr", wr_log.size(), 32'd0);
    end
    txb = '{8'h40, 8'h99};
    txn_write(7'h70);
    check("after_abort_ptr_lit", {24'd0, bus.Reg_ptr}, 32'h41);

    // Randomized transactions
    for (int t = 0; t < 10; t++) begin
      int kind;
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        int n;
        n = $urandom_range(1, 3);
        txb.delete();
        txb.push_back(8'($urandom_range(0, 255)));
        for (int i = 0; i < n; i++) txb.push_back(8'($urandom_range(0, 255)));
        txn_write(7'h70);
      end else if (kind == 1) begin
        txn_read(1'b1, 8'($urandom_range(0, 255)), $urandom_range(1, 3));
      end else if (kind == 2) begin
        txn_read(1'b0, 8'h00, $urandom_range(1, 3));
      end else begin
        logic [6:0] a;
        a = 7'($urandom_range(0, 127));
        if (a == 7'h70) a = 7'h71;
        txb = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
        txn_write(a);
      end
    end

    // Reset while the target drives a 0 data bit (bank byte 0x10)
    bus_start();
    write_byte(8'hE0, 1'b1);
    write_byte(8'h00, 1'b1);
    bus_start();
    write_byte(8'hE1, 1'b1);
    may_drive = 1'b1;
    check("rd_drive_low", {31'd0, sda}, 32'd0);
    rst = 1'b1;
    #10;
    check("midrst_sda", {31'd0, sda}, 32'd1);
    check("midrst_reg_ptr", {24'd0, bus.Reg_ptr}, 32'd0);
    check("midrst_busy", {31'd0, bus.Busy}, 32'd0);
    check("midrst_wr_en", {31'd0, bus.Wr_en}, 32'd0);
    check("midrst_ack", {31'd0, bus.Ack}, 32'd0);
    check("midrst_wr_data", {24'd0, bus.Wr_data}, 32'd0);
    rst       = 1'b0;
    may_drive = 1'b0;
    m_ptr     = 8'h00;
    scl       = 1'b1;
    #(8 * 10);
    txb = '{8'h02, 8'h5A};
    txn_write(7'h70);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
